inst_cache: RTL

INST_CACHE -- requirements
Module: inst_cache

---
 rtl/inst_cache_pkg.sv | 16 +
 rtl/inst_cache_if.sv | 19 +
 rtl/icache_array.sv | 54 +++++
 rtl/inst_cache.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// Shared geometry defaults and controller state encoding for the instruction cache.
package inst_cache_pkg;

    localparam int DEFAULT_LINE_COUNT = 32;
    localparam int DEFAULT_LINE_WORDS = 4;
    localparam int ADDR_W             = 32;
    localparam int WORD_W             = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        REFILL_REQ,
        REFILL_WAIT
    } state_t;

endpackage

// File: rtl/inst_cache_if.sv
// Fetch request/response bundles shared between the instruction queue and the cache.
interface IRequest;
    logic        valid;
    logic        ready;
    logic [31:0] addr;

    modport cache (input valid, input addr, output ready);
    modport queue (output valid, output addr, input ready);
endinterface

interface IResponse;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [63:0] inst_id;

    modport cache (output valid, output addr, output inst, output inst_id);
    modport queue (input valid, input addr, input inst, input inst_id);
endinterface

// File: rtl/icache_array.sv
// Tag/valid/data storage: one combinational read port, one write port, bulk valid clear.
module icache_array
    import inst_cache_pkg::*;
#(
    parameter int LINE_COUNT = DEFAULT_LINE_COUNT,
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
    parameter int TAG_W      = 23
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [$clog2(LINE_COUNT)-1:0] rd_index,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_offset,
    output logic                          rd_valid,
    output logic [TAG_W-1:0]              rd_tag,
    output logic [WORD_W-1:0]             rd_data,
    input  logic                          data_we,
    input  logic                          tag_we,
    input  logic [$clog2(LINE_COUNT)-1:0] wr_index,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_offset,
    input  logic [WORD_W-1:0]             wr_data,
    input  logic [TAG_W-1:0]              wr_tag,
    input  logic                          wr_valid
);

    logic [LINE_COUNT-1:0] valid_q;
    logic [TAG_W-1:0]      tag_mem  [LINE_COUNT];
    logic [WORD_W-1:0]     data_mem [LINE_COUNT*LINE_WORDS];

    // Flush wins over a same-cycle tag write so a refill finishing under flush stays invalid.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[wr_index] <= wr_valid;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; the valid bits alone
    // qualify their contents, and a reset here would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[wr_index] <= wr_tag;
        end
        if (data_we) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: one-cycle hits, word-at-a-time line refill over a
// single-outstanding read bus, fence.i flush of all valid bits.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int LINE_COUNT = DEFAULT_LINE_COUNT,
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    IRequest.cache      ireq,
    IResponse.cache     iresp,
    input  logic        flush,
    output logic        busreq_valid,
    input  logic        busreq_ready,
    output logic [31:0] busreq_addr,
    input  logic        busresp_valid,
    input  logic [31:0] busresp_data
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINE_COUNT);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    state_t            state;
    logic [31:0]       addr_q;
    logic [OFF_W-1:0]  count;
    logic              refill_done;
    logic              refill_flushed;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [WORD_W-1:0] rd_data;
    logic              hit;
    logic              accept;
    logic              fill_beat;
    logic              fill_last;

    assign off = addr_q[OFF_W+1:2];
    assign idx = addr_q[OFF_W+IDX_W+1:OFF_W+2];
    assign tag = addr_q[31:OFF_W+IDX_W+2];

    // The first lookup after a refill answers from the freshly written data even if a
    // flush kept the line invalid; otherwise a flushed refill would loop forever.
    assign hit       = (state == LOOKUP) && (refill_done || (rd_valid && rd_tag == tag));
    assign accept    = ireq.valid && ireq.ready;
    assign fill_beat = (state == REFILL_WAIT) && busresp_valid;
    assign fill_last = fill_beat && (count == LAST_WORD);

    assign ireq.ready    = (state == IDLE) || hit;
    assign iresp.valid   = hit;
    assign iresp.addr    = addr_q;
    assign iresp.inst    = rd_data;
    assign iresp.inst_id = '0;

    // NOTE: all state here is sequential, so every assignment is non-blocking; a
    // blocking '=' would let later statements see the new value within the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            busreq_valid   <= 1'b0;
            busreq_addr    <= '0;
            refill_done    <= 1'b0;
            refill_flushed <= 1'b0;
        end else begin
            refill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= ireq.addr;
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (ireq.valid) begin
                            addr_q <= ireq.addr;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        count          <= '0;
                        refill_flushed <= flush;
                        busreq_valid   <= 1'b1;
                        busreq_addr    <= {addr_q[31:OFF_W+2], {OFF_W{1'b0}}, 2'b00};
                        state          <= REFILL_REQ;
                    end
                end
                REFILL_REQ: begin
                    if (flush) begin
                        refill_flushed <= 1'b1;
                    end
                    if (busreq_ready) begin
                        busreq_valid <= 1'b0;
                        state        <= REFILL_WAIT;
                    end
                end
                REFILL_WAIT: begin
                    if (flush) begin
                        refill_flushed <= 1'b1;
                    end
                    if (busresp_valid) begin
                        if (count == LAST_WORD) begin
                            refill_done <= 1'b1;
                            state       <= LOOKUP;
                        end else begin
                            count        <= count + 1'b1;
                            busreq_valid <= 1'b1;
                            busreq_addr  <= {addr_q[31:OFF_W+2], count + 1'b1, 2'b00};
                            state        <= REFILL_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    icache_array #(
        .LINE_COUNT (LINE_COUNT),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .rd_index  (idx),
        .rd_offset (off),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .data_we   (fill_beat),
        .tag_we    (fill_last),
        .wr_index  (idx),
        .wr_offset (count),
        .wr_data   (busresp_data),
        .wr_tag    (tag),
        .wr_valid  (~refill_flushed)
    );

endmodule
